// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-based hazard and forwarding controller.
// Tracks in-flight destination registers from EX through the last forwarding
// stage. Drives EX operand forward selects, the load-use stall, and the
// redirect flushes. Also keeps saturating stall and flush counters.
module pipe_hazard_unit #(
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16,
  localparam int FSW       = $clog2(FWD_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_wr,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             stall_id,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [FSW-1:0]   ex_fwd1_sel,
  output logic [FSW-1:0]   ex_fwd2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Index 0 is the instruction in EX; index k is k stages after EX.
  logic       valid_q  [0:FWD_STAGES];
  logic [4:0] rd_q     [0:FWD_STAGES];
  logic       rdWr_q   [0:FWD_STAGES];
  logic       isLoad_q [0:FWD_STAGES];

  // Source operands are only needed for the instruction sitting in EX.
  logic [4:0] rs1_q, rs2_q;
  logic       rs1Used_q, rs2Used_q;

  logic             valid0_d;
  logic             loadHazard;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  // A producer matches a source only if it writes a non-zero register.
  function automatic logic srcMatch(input logic v, input logic wr,
                                    input logic [4:0] rd, input logic [4:0] rs);
    return v && wr && (rd == rs) && (rs != 5'd0);
  endfunction

  // Forward selects come only from registered state; scanning from the oldest
  // stage down lets the youngest matching producer overwrite the selection.
  always_comb begin
    ex_fwd1_sel = '0;
    ex_fwd2_sel = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (valid_q[0] && rs1Used_q && srcMatch(valid_q[k], rdWr_q[k], rd_q[k], rs1_q))
        ex_fwd1_sel = FSW'(k);
      if (valid_q[0] && rs2Used_q && srcMatch(valid_q[k], rdWr_q[k], rd_q[k], rs2_q))
        ex_fwd2_sel = FSW'(k);
    end
  end

  // Load-use detection: a load whose data is not yet available feeds a used ID source.
  always_comb begin
    loadHazard = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (valid_q[j] && isLoad_q[j] &&
          ((id_rs1_used && srcMatch(valid_q[j], rdWr_q[j], rd_q[j], id_rs1)) ||
           (id_rs2_used && srcMatch(valid_q[j], rdWr_q[j], rd_q[j], id_rs2))))
        loadHazard = 1'b1;
    end
  end

  // Redirect wins over the stall since the stalled ID instruction is wrong-path.
  always_comb begin
    stall_id   = id_valid && loadHazard && !ex_redirect;
    flush_ifid = ex_redirect;
    flush_idex = ex_redirect;
    valid0_d   = id_valid && !stall_id && !ex_redirect;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stall_id && (stallCnt_q != {CNT_W{1'b1}}))
      stallCnt_d = stallCnt_q + 1'b1;
    if (ex_redirect && (flushCnt_q != {CNT_W{1'b1}}))
      flushCnt_d = flushCnt_q + 1'b1;
  end

  // Scoreboard shift, EX-entry load and counter update; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= FWD_STAGES; k++)
        valid_q[k] <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        valid_q[k]  <= valid_q[k-1];
        rd_q[k]     <= rd_q[k-1];
        rdWr_q[k]   <= rdWr_q[k-1];
        isLoad_q[k] <= isLoad_q[k-1];
      end
      valid_q[0]  <= valid0_d;
      rd_q[0]     <= id_rd;
      rdWr_q[0]   <= id_rd_wr;
      isLoad_q[0] <= id_is_load;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rs1Used_q   <= id_rs1_used;
      rs2Used_q   <= id_rs2_used;
      stallCnt_q  <= stallCnt_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit: two instances.
// Instance A uses the default geometry (2 forwarding stages, load latency 1).
// Instance B uses 3 forwarding stages, load latency 2 and 2-bit counters.
// Both are driven from tables of hand-computed vectors.
module tb_pipe_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } inst_t;

  typedef struct {
    inst_t ins;
    logic  redir;
    logic  rstIn;
    logic  stall;
    logic  flush;
    int    f1;
    int    f2;
    int    sc;
    int    fc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  inst_t insA, insB;
  logic  redirA, redirB, rstA, rstB;

  logic        stallA, fIfA, fIdA, stallB, fIfB, fIdB;
  logic [1:0]  f1A, f2A, f1B, f2B;
  logic [15:0] scA, fcA;
  logic [1:0]  scB, fcB;

  int total  = 0;
  int passed = 0;

  pipe_hazard_unit #(.FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rstA),
    .id_valid(insA.valid), .id_rs1(insA.rs1), .id_rs2(insA.rs2),
    .id_rs1_used(insA.u1), .id_rs2_used(insA.u2),
    .id_rd(insA.rd), .id_rd_wr(insA.wr), .id_is_load(insA.ld),
    .ex_redirect(redirA),
    .stall_id(stallA), .flush_ifid(fIfA), .flush_idex(fIdA),
    .ex_fwd1_sel(f1A), .ex_fwd2_sel(f2A),
    .stall_cnt(scA), .flush_cnt(fcA)
  );

  pipe_hazard_unit #(.FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(2)) dutB (
    .clk(clk), .rst(rstB),
    .id_valid(insB.valid), .id_rs1(insB.rs1), .id_rs2(insB.rs2),
    .id_rs1_used(insB.u1), .id_rs2_used(insB.u2),
    .id_rd(insB.rd), .id_rd_wr(insB.wr), .id_is_load(insB.ld),
    .ex_redirect(redirB),
    .stall_id(stallB), .flush_ifid(fIfB), .flush_idex(fIdB),
    .ex_fwd1_sel(f1B), .ex_fwd2_sel(f2B),
    .stall_cnt(scB), .flush_cnt(fcB)
  );

  function automatic inst_t nop();
    return '0;
  endfunction

  function automatic inst_t alu(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2);
    inst_t i;
    i = '0;
    i.valid = 1'b1; i.rd = rd; i.wr = 1'b1;
    i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1;
    return i;
  endfunction

  function automatic inst_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    inst_t i;
    i = '0;
    i.valid = 1'b1; i.rd = rd; i.wr = 1'b1; i.ld = 1'b1;
    i.rs1 = rs1; i.u1 = 1'b1;
    return i;
  endfunction

  function automatic vec_t mk(input inst_t i, input logic redir, input logic r,
                              input logic st, input logic fl, input int f1,
                              input int f2, input int sc, input int fc);
    vec_t v;
    v.ins = i; v.redir = redir; v.rstIn = r; v.stall = st; v.flush = fl;
    v.f1 = f1; v.f2 = f2; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic applyStimulus(input int dut, input vec_t v);
    if (dut == 0) begin
      insA = v.ins; redirA = v.redir; rstA = v.rstIn;
    end else begin
      insB = v.ins; redirB = v.redir; rstB = v.rstIn;
    end
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Drive one vector half a cycle before the edge and check the settled outputs.
  task automatic runVector(input int dut, input int idx, input vec_t v);
    string tag;
    @(negedge clk);
    applyStimulus(dut, v);
    #1;
    tag = $sformatf("%s[%0d]", (dut == 0) ? "A" : "B", idx);
    if (dut == 0) begin
      checkOutput({tag, ".stall"},      int'(stallA), int'(v.stall));
      checkOutput({tag, ".flush_ifid"}, int'(fIfA),   int'(v.flush));
      checkOutput({tag, ".flush_idex"}, int'(fIdA),   int'(v.flush));
      checkOutput({tag, ".fwd1"},       int'(f1A),    v.f1);
      checkOutput({tag, ".fwd2"},       int'(f2A),    v.f2);
      checkOutput({tag, ".stall_cnt"},  int'(scA),    v.sc);
      checkOutput({tag, ".flush_cnt"},  int'(fcA),    v.fc);
    end else begin
      checkOutput({tag, ".stall"},      int'(stallB), int'(v.stall));
      checkOutput({tag, ".flush_ifid"}, int'(fIfB),   int'(v.flush));
      checkOutput({tag, ".flush_idex"}, int'(fIdB),   int'(v.flush));
      checkOutput({tag, ".fwd1"},       int'(f1B),    v.f1);
      checkOutput({tag, ".fwd2"},       int'(f2B),    v.f2);
      checkOutput({tag, ".stall_cnt"},  int'(scB),    v.sc);
      checkOutput({tag, ".flush_cnt"},  int'(fcB),    v.fc);
    end
  endtask

  vec_t vecA [0:25];
  vec_t vecB [0:11];

  initial begin
    // ins, redirect, rst, stall, flush, fwd1, fwd2, stall_cnt, flush_cnt
    vecA[0]  = mk(nop(),         0, 0, 0, 0, 0, 0, 0, 0); // reset state
    vecA[1]  = mk(alu(5, 1, 2),  0, 0, 0, 0, 0, 0, 0, 0); // ADD x5
    vecA[2]  = mk(alu(6, 5, 5),  0, 0, 0, 0, 0, 0, 0, 0); // ADD x6,x5,x5
    vecA[3]  = mk(nop(),         0, 0, 0, 0, 1, 1, 0, 0); // consumer in EX
    vecA[4]  = mk(nop(),         0, 0, 0, 0, 0, 0, 0, 0);
    vecA[5]  = mk(alu(5, 0, 0),  0, 0, 0, 0, 0, 0, 0, 0); // ADD x5
    vecA[6]  = mk(nop(),         0, 0, 0, 0, 0, 0, 0, 0);
    vecA[7]  = mk(alu(7, 5, 1),  0, 0, 0, 0, 0, 0, 0, 0); // SUB x7,x5,x1
    vecA[8]  = mk(nop(),         0, 0, 0, 0, 2, 0, 0, 0); // distance 2
    vecA[9]  = mk(alu(5, 0, 0),  0, 0, 0, 0, 0, 0, 0, 0); // ADD x5
    vecA[10] = mk(alu(5, 0, 0),  0, 0, 0, 0, 0, 0, 0, 0); // ADD x5 again
    vecA[11] = mk(alu(7, 5, 5),  0, 0, 0, 0, 0, 0, 0, 0);
    vecA[12] = mk(nop(),         0, 0, 0, 0, 1, 1, 0, 0); // youngest wins
    vecA[13] = mk(lw(3, 2),      0, 0, 0, 0, 0, 0, 0, 0); // LW x3
    vecA[14] = mk(alu(4, 3, 0),  0, 0, 1, 0, 0, 0, 0, 0); // load-use stall
    vecA[15] = mk(alu(4, 3, 0),  0, 0, 0, 0, 0, 0, 1, 0); // stall released
    vecA[16] = mk(nop(),         0, 0, 0, 0, 2, 0, 1, 0); // consumer sel 2
    vecA[17] = mk(lw(0, 1),      0, 0, 0, 0, 0, 0, 1, 0); // LW x0
    vecA[18] = mk(alu(1, 0, 0),  0, 0, 0, 0, 0, 0, 1, 0); // no stall on x0
    vecA[19] = mk(nop(),         0, 0, 0, 0, 0, 0, 1, 0); // sels 0 on x0
    vecA[20] = mk(lw(3, 0),      0, 0, 0, 0, 0, 0, 1, 0); // LW x3
    vecA[21] = mk(alu(4, 3, 0),  1, 0, 0, 1, 0, 0, 1, 0); // redirect beats stall
    vecA[22] = mk(alu(4, 3, 0),  0, 0, 0, 0, 0, 0, 1, 1); // e[0] was flushed
    vecA[23] = mk(nop(),         1, 0, 0, 1, 2, 0, 1, 1); // redirect, ADD in EX
    vecA[24] = mk(nop(),         1, 0, 0, 1, 0, 0, 1, 2); // back-to-back
    vecA[25] = mk(nop(),         0, 0, 0, 0, 0, 0, 1, 3);

    vecB[0]  = mk(nop(),         0, 0, 0, 0, 0, 0, 0, 0); // reset state
    vecB[1]  = mk(lw(3, 0),      0, 0, 0, 0, 0, 0, 0, 0);
    vecB[2]  = mk(alu(4, 3, 0),  0, 0, 1, 0, 0, 0, 0, 0); // stall 1 of 2
    vecB[3]  = mk(alu(4, 3, 0),  0, 0, 1, 0, 0, 0, 1, 0); // stall 2 of 2
    vecB[4]  = mk(alu(4, 3, 0),  0, 0, 0, 0, 0, 0, 2, 0);
    vecB[5]  = mk(nop(),         0, 0, 0, 0, 3, 0, 2, 0); // consumer sel 3
    vecB[6]  = mk(lw(3, 0),      0, 0, 0, 0, 0, 0, 2, 0);
    vecB[7]  = mk(alu(4, 3, 0),  0, 0, 1, 0, 0, 0, 2, 0);
    vecB[8]  = mk(alu(4, 3, 0),  0, 0, 1, 0, 0, 0, 3, 0);
    vecB[9]  = mk(alu(4, 3, 0),  0, 0, 0, 0, 0, 0, 3, 0); // 4 stalls, held at 3
    vecB[10] = mk(lw(3, 0),      0, 0, 0, 0, 3, 0, 3, 0);
    vecB[11] = mk(alu(4, 3, 0),  0, 0, 1, 0, 0, 0, 3, 0); // 5th stall

    insA = '0; insB = '0; redirA = 1'b0; redirB = 1'b0;
    rstA = 1'b1; rstB = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 26; i++) runVector(0, i, vecA[i]);
    for (int i = 0; i < 12; i++) runVector(1, i, vecB[i]);

    // Reset in the middle of a stall: saturated counter must not have wrapped.
    runVector(1, 12, mk(alu(4, 3, 0), 0, 1, 1, 0, 0, 0, 3, 0));
    // After reset everything in flight is gone even with the consumer still in ID.
    runVector(1, 13, mk(alu(4, 3, 0), 0, 0, 0, 0, 0, 0, 0, 0));
    runVector(1, 14, mk(nop(),        0, 0, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks the destination register of every in-flight instruction from ID/EX through the last forwarding stage in an internal shift-register scoreboard. From that state it drives the EX operand forwarding selects, the load-use stall and the branch/jump flush. The depth of forwarding and the load-data latency are parameters; the hardwired 2-stage forwarding unit covers only one fixed case. Saturating stall and flush counters are included for performance measurement.

## Interface

Parameters:
- FWD_STAGES, 2: stages after EX that can forward (1 = EX/MEM, 2 = MEM/WB, …); range 1–4.
- LOAD_LAT, 1: number of post-EX stages in which load data is not yet available; range 1 to FWD_STAGES.
- CNT_W, 16: width of the performance counters.
- FSW, $clog2(FWD_STAGES+1): width of the forward select (derived, not user-set).

Ports (reset rst, synchronous, active-high; clock clk):
- clk: in, 1, clock.
- rst: in, 1, synchronous active-high reset.
- id_valid: in, 1, the ID-stage instruction is valid.
- id_rs1: in, 5, ID-stage source register 1 address.
- id_rs2: in, 5, ID-stage source register 2 address.
- id_rs1_used: in, 1, the ID instruction reads rs1.
- id_rs2_used: in, 1, the ID instruction reads rs2.
- id_rd: in, 5, ID-stage destination register.
- id_rd_wr: in, 1, the ID instruction writes rd.
- id_is_load: in, 1, the ID instruction is a load.
- ex_redirect: in, 1, a branch taken or jump resolved in EX this cycle.
- stall_id: out, 1, hold PC and IF/ID; insert a bubble into ID/EX.
- flush_ifid: out, 1, squash IF/ID.
- flush_idex: out, 1, squash ID/EX (bubble).
- ex_fwd1_sel: out, FSW, source for EX operand 1: 0 = register file, k = stage k after EX.
- ex_fwd2_sel: out, FSW, the same for operand 2.
- stall_cnt: out, CNT_W, count of stall cycles.
- flush_cnt: out, CNT_W, count of redirects.

## Operation

- Scoreboard entries e[0..FWD_STAGES]:
  - e[0] is the instruction now in EX. It holds {valid, rd, rd_wr, is_load, rs1, rs2, rs1_used, rs2_used}.
  - e[k], k ≥ 1, is the instruction k stages after EX. It holds {valid, rd, rd_wr, is_load}.
- Every cycle, e[k] <= e[k-1] for k ≥ 1.
- e[0] loads the ID inputs (valid = id_valid) only when neither stall_id nor ex_redirect is active. Otherwise e[0].valid <= 0.
- A match at stage k requires e[k].valid, e[k].rd_wr, e[k].rd == rs, and rs != 0. Register x0 never matches.
- Forward select, operand n (combinational, from the e[] state):
  - If e[0].valid and rsN_used: select the smallest k in 1..FWD_STAGES that matches e[0].rsN.
  - Otherwise select 0.
  - The nearest (youngest) producer wins.
- Load-use stall (combinational):
  - Asserted when id_valid, a used ID source matches e[j] for some j in 0..LOAD_LAT-1, and e[j].is_load.
  - It deasserts by itself as bubbles shift the load forward. Stall length is LOAD_LAT-j cycles.
- Redirect:
  - ex_redirect forces flush_ifid = 1 and flush_idex = 1 in the same cycle.
  - When ex_redirect is high, stall_id = 0. Redirect has priority because the stalled ID instruction is wrong-path.
  - The redirecting instruction itself, in e[0], advances normally.
- Counters:
  - stall_cnt increments on each cycle with stall_id = 1.
  - flush_cnt increments on each cycle with ex_redirect = 1.
  - Both saturate at 2^CNT_W − 1 and never wrap.
- The register file is write-through. An instruction past stage FWD_STAGES is visible through fwd_sel = 0.

## Timing

- Reset (the rst edge):
  - All e[].valid = 0 and both counters = 0.
  - Outputs after reset: stall_id = 0, flush_ifid = 0, flush_idex = 0, ex_fwd1_sel = 0, ex_fwd2_sel = 0.
  - Reset in mid-stall or mid-flush discards all in-flight state.
  - rst has priority over ex_redirect and the shift.
- stall_id and the flushes are combinational on the current-cycle inputs plus state, and are used in the same cycle.
- The fwd selects depend only on registers, so they are glitch-free for the whole EX cycle.
- An instruction presented in ID at cycle t, not stalled, sits in e[0] at t+1 and in e[k] at t+1+k.
- Back-to-back redirects each flush. A redirect during a stall cancels the stall in that cycle.

## Test plan

- Producer-consumer: ADD x5 then ADD x6,x5,x5 back-to-back → ex_fwd1_sel = ex_fwd2_sel = 1 when the consumer is in EX; no stall.
- Distance 2: ADD x5, NOP, SUB x7,x5,x1 → ex_fwd1_sel = 2, ex_fwd2_sel = 0. The same with a double write to x5 at distances 1 and 2 → sel = 1 (youngest wins).
- Load-use, LOAD_LAT = 1:
  - LW x3 then ADD x4,x3,x0 → stall_id = 1 for exactly 1 cycle, and stall_cnt = 1.
  - The consumer then enters EX with ex_fwd1_sel = 2.
  - With LOAD_LAT = 2 and FWD_STAGES = 3 → 2 stall cycles, then sel = 3.
- x0: LW x0 then ADD x1,x0,x0 → no stall, both sels 0.
- Redirect vs stall: LW x3; ADD x4,x3 in ID while a branch in EX asserts ex_redirect → stall_id = 0, flush_ifid = flush_idex = 1, flush_cnt += 1. The next cycle e[0] is invalid.
- Saturation and reset, CNT_W = 2:
  - 5 stall cycles → stall_cnt = 3.
  - Assert rst mid-stall → next cycle all outputs 0 and counters 0.
